mem_port_arbiter: RTL

Shares one variable-latency memory port between the instruction-fetch requester and the data load/store requester of the multicycle core. Requests are serialized and latched, then driven to memory. The result is returned to the winning requester as a one-cycle ack. A simultaneous conflict is resolved round-robin. A timeout counter turns a hung memory access into an error response, so the core sequencer never deadlocks.

---
 rtl/mem_port_arbiter_if.sv | 37 +++
 rtl/mem_port_arbiter.sv | 79 +++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch/data requester and shared memory-port signals of the arbiter
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                i_req;
    logic [ADDR_W-1:0]   i_addr;
    logic                i_ack;
    logic [DATA_W-1:0]   i_rdata;
    logic                i_err;
    logic                d_req;
    logic                d_we;
    logic [DATA_W/8-1:0] d_be;
    logic [ADDR_W-1:0]   d_addr;
    logic [DATA_W-1:0]   d_wdata;
    logic                d_ack;
    logic [DATA_W-1:0]   d_rdata;
    logic                d_err;
    logic                mem_en;
    logic                mem_we;
    logic [DATA_W/8-1:0] mem_be;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_ack;
    logic [DATA_W-1:0]   mem_rdata;
    logic                busy;
    modport master (
        input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ack, mem_rdata,
        output i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
    );
    modport slave (
        output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, mem_ack, mem_rdata,
        input  i_ack, i_rdata, i_err, d_ack, d_rdata, d_err,
               mem_en, mem_we, mem_be, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin fetch/data arbiter for one variable-latency memory port with timeout
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input logic                clk,
    input logic                rst,
    mem_port_arbiter_if.master bus
);
    localparam int BW = DATA_W / 8;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;
    state_t            r_state, w_next;
    logic              r_last_d, r_gnt_d, r_we, r_err;
    logic [BW-1:0]     r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_rdata;
    logic [CW-1:0]     r_cnt;
    logic              w_any, w_gnt_d, w_to, w_mem, w_i_ack, w_d_ack;
    always_comb begin
        w_any   = bus.i_req | bus.d_req;
        w_gnt_d = bus.d_req & (~bus.i_req | ~r_last_d);
        w_to    = (TIMEOUT != 0) && (32'(r_cnt) == TIMEOUT - 1);
        w_next  = r_state == IDLE ? (w_any ? MEM : IDLE) :
                  r_state == MEM  ? ((bus.mem_ack || w_to) ? RESP : MEM) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_last_d <= 1'b1;
            r_gnt_d  <= 1'b0;
            r_we     <= 1'b0;
            r_be     <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_gnt_d  <= w_gnt_d;
                r_last_d <= w_gnt_d;
                r_we     <= w_gnt_d & bus.d_we;
                r_be     <= w_gnt_d ? bus.d_be : '1;
                r_addr   <= w_gnt_d ? bus.d_addr : bus.i_addr;
                r_wdata  <= w_gnt_d ? bus.d_wdata : '0;
                r_cnt    <= '0;
            end else if (r_state == MEM) begin
                // a completing mem_ack takes precedence over an expiring timeout
                if (bus.mem_ack) begin
                    r_rdata <= r_we ? '0 : bus.mem_rdata;
                    r_err   <= 1'b0;
                end else if (w_to) begin
                    r_rdata <= '0;
                    r_err   <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end
    assign w_mem         = r_state == MEM;
    assign w_i_ack       = r_state == RESP && !r_gnt_d;
    assign w_d_ack       = r_state == RESP && r_gnt_d;
    assign bus.mem_en    = w_mem;
    assign bus.mem_we    = w_mem & r_we;
    assign bus.mem_be    = r_be;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.i_ack     = w_i_ack;
    assign bus.i_rdata   = w_i_ack ? r_rdata : '0;
    assign bus.i_err     = w_i_ack & r_err;
    assign bus.d_ack     = w_d_ack;
    assign bus.d_rdata   = w_d_ack ? r_rdata : '0;
    assign bus.d_err     = w_d_ack & r_err;
    assign bus.busy      = r_state != IDLE;
endmodule
